// File: rtl/affine_tap_sum.sv
`timescale 1ns/1ps
// Six-tap product sum with round-half-up and arithmetic shift; clamps to [0, 2^BIT_DEPTH-1] when AFFINE_TAP_SUM_CLIP_EN is defined.
// Latency: 3 cycles, 1 beat/cycle. Backpressure: a single global enable freezes every stage while out_valid && !out_ready.
module affine_tap_sum #(
    parameter int SHIFT     = 6,
    parameter int ROW_LEN   = 4,
    parameter int BIT_DEPTH = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [16:0] p0,
    input  logic signed [16:0] p1,
    input  logic signed [16:0] p2,
    input  logic signed [16:0] p3,
    input  logic signed [16:0] p4,
    input  logic signed [16:0] p5,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [13:0] y,
    output logic               out_last
);
    localparam int CW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(ROW_LEN - 1);
    localparam logic signed [20:0] RND  = 21'sd1 <<< (SHIFT - 1);
    localparam logic signed [20:0] MAXV = 21'((1 << BIT_DEPTH) - 1);

    logic               en;
    logic               v1_q, v2_q, vo_q;
    logic signed [17:0] s01_q, s23_q, s45_q;
    logic signed [17:0] s01_d, s23_d, s45_d;
    logic signed [19:0] sum_q, sum_d;
    logic signed [20:0] rnd, shr;
    logic signed [13:0] y_q, y_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    assign en       = !vo_q || out_ready;
    assign in_ready = en;

    always_comb begin
        s01_d = {p0[16], p0} + {p1[16], p1};
        s23_d = {p2[16], p2} + {p3[16], p3};
        s45_d = {p4[16], p4} + {p5[16], p5};
        sum_d = {{2{s01_q[17]}}, s01_q} + {{2{s23_q[17]}}, s23_q} + {{2{s45_q[17]}}, s45_q};
        rnd   = {sum_q[19], sum_q} + RND;
        shr   = rnd >>> SHIFT;
`ifdef AFFINE_TAP_SUM_CLIP_EN
        if (shr < 0) begin
            y_d = '0;
        end else if (shr > MAXV) begin
            y_d = 14'(MAXV);
        end else begin
            y_d = 14'(shr);
        end
`else
        y_d = 14'(shr);
`endif
        cnt_d = cnt_q;
        if (vo_q && out_ready) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Control state and y reset; bubbles advance like beats so cadence is preserved.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            vo_q  <= 1'b0;
            y_q   <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (en) begin
                v1_q <= in_valid;
                v2_q <= v1_q;
                vo_q <= v2_q;
                y_q  <= y_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s01_q <= s01_d;
            s23_q <= s23_d;
            s45_q <= s45_d;
            sum_q <= sum_d;
        end
    end

    assign out_valid = vo_q;
    assign y         = y_q;
    assign out_last  = vo_q && (cnt_q == LAST);
endmodule
